mem_responder: RTL and testbench

- Word-addressed data-memory responder: the memory-side end of the core's load/store request interface.
- Replaces the combinational data memory for the upcoming multi-cycle and pipelined cores.
- Accepts one request at a time over a valid/ready handshake and returns read data or a write acknowledgement after a programmable latency.
- Flags misaligned or out-of-range accesses with an error response.

---
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed data-memory responder for the core's load/store port.
// One request in flight; response after a fixed, parameterised latency.
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EXEC,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    logic          idle_ready;
    logic          accept;
    logic          exec;
    logic [29:0]   word;
    logic          addr_err;

    logic          wr_q;
    logic          err_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH];

    assign word     = req_addr[31:2];
    assign addr_err = (req_addr[1:0] != 2'b00) ||
                      (word >= 30'(DEPTH));

    // Never accept while reset is held, even if the state is already IDLE.
    assign req_ready = idle_ready && !rst;
    assign accept    = req_valid && req_ready;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idle_ready = 1'b0;
        resp_valid = 1'b0;
        exec       = 1'b0;
        unique case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (req_valid) begin
                    if (LAT_C != 4'd0) begin
                        state_d = WAIT;
                        cnt_d   = LAT_C;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = EXEC;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            EXEC: begin
                exec    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request at acceptance; the core may change it afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            wr_q    <= req_wr;
            err_q   <= addr_err;
            idx_q   <= word[AW-1:0];
            wdata_q <= req_wdata;
        end
    end

    // Store commit; a store whose EXEC edge sees reset is dropped.
    always_ff @(posedge clk) begin
        if (exec && !rst && wr_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Response registers, loaded in EXEC and held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (exec) begin
            resp_rdata <= (!wr_q && !err_q) ? mem[idx_q] : 32'd0;
            resp_err   <= err_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance (a_*)
// and LATENCY=0 instance (b_*) sharing one clock.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req_valid, a_req_ready, a_req_wr;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err;

    logic        b_rst, b_req_valid, b_req_ready, b_req_wr;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] b_q[$];
    logic [31:0] b_eq[$];

    mem_responder #(.DEPTH(1024), .LATENCY(2)) u_a (
        .clk(clk), .rst(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_wr(a_req_wr), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(0)) u_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_wr(b_req_wr), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    always @(negedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b_resp_valid && b_resp_ready) begin
            b_q.push_back(b_resp_rdata);
            b_eq.push_back(32'(b_resp_err));
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic a_xact(input string tag,
                          input logic wr,
                          input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input int hold,
                          input logic [31:0] exp_rd,
                          input logic exp_err);
        int n;
        bit seen;
        @(negedge clk);
        a_req_wr     = wr;
        a_req_addr   = addr;
        a_req_wdata  = wdata;
        a_req_valid  = 1'b1;
        a_resp_ready = 1'b0;
        chk({tag, "_rdy"}, 32'(a_req_ready), 32'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_req_wr    = ~wr;
        a_req_addr  = 32'h0000_0004;
        a_req_wdata = 32'h5A5A_5A5A;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = a_resp_valid;
        end
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_rd"}, a_resp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(a_resp_err), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_hv"}, 32'(a_resp_valid), 32'd1);
            chk({tag, "_hrd"}, a_resp_rdata, exp_rd);
            chk({tag, "_herr"}, 32'(a_resp_err), 32'(exp_err));
            chk({tag, "_hrdy"}, 32'(a_req_ready), 32'd0);
        end
        a_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idlev"}, 32'(a_resp_valid), 32'd0);
        chk({tag, "_idler"}, 32'(a_req_ready), 32'd1);
    endtask

    initial begin
        int n;
        int acc;
        int acc_cyc[2];
        a_rst = 1'b1; a_req_valid = 1'b0; a_req_wr = 1'b0;
        a_req_addr = 32'd0; a_req_wdata = 32'd0; a_resp_ready = 1'b0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_wr = 1'b0;
        b_req_addr = 32'd0; b_req_wdata = 32'd0; b_resp_ready = 1'b1;

        @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(a_req_ready), 32'd0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        chk("post_rdy", 32'(a_req_ready), 32'd1);
        chk("post_v", 32'(a_resp_valid), 32'd0);
        chk("post_err", 32'(a_resp_err), 32'd0);
        chk("post_rd", a_resp_rdata, 32'd0);

        a_xact("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'd0, 1'b0);
        a_xact("ld10", 1'b0, 32'h10, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
        a_xact("bp", 1'b0, 32'h10, 32'd0, 5, 32'hDEAD_BEEF, 1'b0);
        a_xact("ld13", 1'b0, 32'h13, 32'd0, 0, 32'd0, 1'b1);
        a_xact("st0", 1'b1, 32'h0, 32'hCAFE_F00D, 0, 32'd0, 1'b0);
        a_xact("st1000", 1'b1, 32'h1000, 32'h1234_5678, 0,
               32'd0, 1'b1);
        a_xact("ld0", 1'b0, 32'h0, 32'd0, 0, 32'hCAFE_F00D, 1'b0);
        a_xact("ldoor", 1'b0, 32'h1000, 32'd0, 0, 32'd0, 1'b1);
        a_xact("st8", 1'b1, 32'h8, 32'h1111_2222, 0, 32'd0, 1'b0);

        @(negedge clk);
        a_req_wr    = 1'b1;
        a_req_addr  = 32'h8;
        a_req_wdata = 32'hAAAA_5555;
        a_req_valid = 1'b1;
        a_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mrst_v", 32'(a_resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mrst_nv", 32'(a_resp_valid), 32'd0);
        end
        a_xact("ld8", 1'b0, 32'h8, 32'd0, 0, 32'h1111_2222, 1'b0);

        @(negedge clk);
        b_req_wr    = 1'b1;
        b_req_addr  = 32'h4;
        b_req_wdata = 32'h5;
        b_req_valid = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 2 && n < 30) begin
            if (n > 0) @(negedge clk);
            n++;
            if (b_req_valid && b_req_ready) begin
                acc_cyc[acc] = cyc;
                acc++;
                @(posedge clk);
                #1;
                b_req_wr    = 1'b0;
                b_req_wdata = 32'd0;
                if (acc == 2) b_req_valid = 1'b0;
            end
        end
        chk("b_acc", 32'(acc), 32'd2);
        if (acc == 2) begin
            chk("b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        end
        repeat (6) @(negedge clk);
        chk("b_nresp", 32'(b_q.size()), 32'd2);
        if (b_q.size() >= 2) begin
            chk("b_strd", b_q[0], 32'd0);
            chk("b_sterr", b_eq[0], 32'd0);
            chk("b_ldrd", b_q[1], 32'd5);
            chk("b_lderr", b_eq[1], 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
